// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: register-file sizing, register index type and
// the read-data bundle that decode hands to ID/EX.
package rv32i_types;

    localparam int REGF_NREG   = 32;
    localparam int REGF_PEND_W = 2;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] xlen_t;

    typedef struct packed {
        xlen_t rs1_v;
        xlen_t rs2_v;
    } regf_rd_t;

endpackage

// File: rtl/regf_scoreboard.sv
// Per-register pending-writer counters for RAW hazard detection in decode.
// Build option REGF_BYPASS_EN: busy discounts a writer retiring this cycle.
module regf_scoreboard
    import rv32i_types::*;
#(
    parameter int NREG   = REGF_NREG,
    parameter int PEND_W = REGF_PEND_W
) (
    input  logic     clk,
    input  logic     rst_n,
    input  reg_idx_t rs1_s,
    input  reg_idx_t rs2_s,
    input  reg_idx_t wb_rd_s,
    input  logic     wb_regf_we,
    input  reg_idx_t iss_rd_s,
    input  logic     iss_we,
    output logic     rs1_busy,
    output logic     rs2_busy,
    output logic     iss_ready
);

    localparam logic [PEND_W-1:0] CNT_MAX  = '1;
    localparam logic [PEND_W-1:0] CNT_ZERO = '0;
    localparam logic [PEND_W-1:0] CNT_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};

    logic [PEND_W-1:0] count_q [NREG];
    logic [PEND_W-1:0] count_d [NREG];
    logic [NREG-1:0]   inc_vec;
    logic [NREG-1:0]   dec_vec;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (iss_we && iss_rd_s != '0) inc_vec[iss_rd_s] = 1'b1;
        if (wb_regf_we && wb_rd_s != '0) dec_vec[wb_rd_s] = 1'b1;
    end

    // Issue and retire on the same register cancel; out-of-range moves saturate.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            count_d[i] = count_q[i];
            if (inc_vec[i] && !dec_vec[i] && count_q[i] != CNT_MAX)
                count_d[i] = count_q[i] + CNT_ONE;
            else if (dec_vec[i] && !inc_vec[i] && count_q[i] != CNT_ZERO)
                count_d[i] = count_q[i] - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) count_q[i] <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Handshake: decode raises iss_we only in a cycle where iss_ready is high;
    // iss_ready depends only on iss_rd_s and state, never on iss_we.
    assign iss_ready = (iss_rd_s == '0) || (count_q[iss_rd_s] != CNT_MAX);

`ifdef REGF_BYPASS_EN
    logic ret1, ret2;
    assign ret1 = wb_regf_we && (wb_rd_s == rs1_s) && (rs1_s != '0);
    assign ret2 = wb_regf_we && (wb_rd_s == rs2_s) && (rs2_s != '0);
    assign rs1_busy = (count_q[rs1_s] - (ret1 ? CNT_ONE : CNT_ZERO)) != CNT_ZERO;
    assign rs2_busy = (count_q[rs2_s] - (ret2 ? CNT_ONE : CNT_ZERO)) != CNT_ZERO;
`else
    assign rs1_busy = count_q[rs1_s] != CNT_ZERO;
    assign rs2_busy = count_q[rs2_s] != CNT_ZERO;
`endif

    ap_no_dec_at_zero: assert property (@(posedge clk) disable iff (!rst_n)
        (wb_regf_we && wb_rd_s != '0 && !(iss_we && iss_rd_s == wb_rd_s))
            |-> count_q[wb_rd_s] != CNT_ZERO);

    ap_no_inc_at_max: assert property (@(posedge clk) disable iff (!rst_n)
        (iss_we && iss_rd_s != '0 && !(wb_regf_we && wb_rd_s == iss_rd_s))
            |-> count_q[iss_rd_s] != CNT_MAX);

endmodule

// File: rtl/regfile_sb.sv
// RV32I architectural register file with registered read ports and an
// integrated pending-write scoreboard. Build option REGF_BYPASS_EN enables write-through reads.
module regfile_sb
    import rv32i_types::*;
#(
    parameter int NREG   = REGF_NREG,
    parameter int PEND_W = REGF_PEND_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_s,
    input  logic [4:0]  rs2_s,
    input  logic        rd_en,
    output logic [31:0] rs1_v,
    output logic [31:0] rs2_v,
    input  logic [31:0] wb_rd_v,
    input  logic [4:0]  wb_rd_s,
    input  logic        wb_regf_we,
    input  logic [4:0]  iss_rd_s,
    input  logic        iss_we,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        iss_ready
);

    xlen_t    regs_q [NREG];
    xlen_t    regs_d [NREG];
    regf_rd_t rd_q;
    regf_rd_t rd_d;
    logic     byp1;
    logic     byp2;

    always_comb begin
        regs_d = regs_q;
        if (wb_regf_we && wb_rd_s != '0) regs_d[wb_rd_s] = wb_rd_v;
    end

`ifdef REGF_BYPASS_EN
    assign byp1 = wb_regf_we && (wb_rd_s == rs1_s);
    assign byp2 = wb_regf_we && (wb_rd_s == rs2_s);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // x0 is forced to zero here rather than relying on regs_q[0] staying clear.
    always_comb begin
        rd_d = rd_q;
        if (rd_en) begin
            rd_d.rs1_v = (rs1_s == '0) ? '0 : (byp1 ? wb_rd_v : regs_q[rs1_s]);
            rd_d.rs2_v = (rs2_s == '0) ? '0 : (byp2 ? wb_rd_v : regs_q[rs2_s]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            rd_q <= '0;
        end else begin
            regs_q <= regs_d;
            rd_q   <= rd_d;
        end
    end

    assign rs1_v = rd_q.rs1_v;
    assign rs2_v = rd_q.rs2_v;

    regf_scoreboard #(
        .NREG   (NREG),
        .PEND_W (PEND_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1_s      (rs1_s),
        .rs2_s      (rs2_s),
        .wb_rd_s    (wb_rd_s),
        .wb_regf_we (wb_regf_we),
        .iss_rd_s   (iss_rd_s),
        .iss_we     (iss_we),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .iss_ready  (iss_ready)
    );

endmodule
